// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
//   pipe_ctrl_state_e : controller FSM states (RUN, MEM_WAIT, FLUSH, TRAP)
//   trap_cause_e      : reported trap cause (NONE, ILLEGAL, BUS_TIMEOUT)
//   cnt_width()       : width of a counter that must reach max(a, b)
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    TRAP     = 2'd3
  } pipe_ctrl_state_e;

  typedef enum logic [1:0] {
    NONE        = 2'd0,
    ILLEGAL     = 2'd1,
    BUS_TIMEOUT = 2'd2
  } trap_cause_e;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// pipe_fwd_unit: register-match and forward request for one source operand.
// Build option: PIPE_CTRL_FWD_EN enables forwarding; otherwise fwd is tied 0
// and the top turns a match into a one-cycle stall.
// Ports:
//   rs          in  5 : source register in decode-execute
//   rd_m2w      in  5 : destination register in memory-writeback
//   reg_wr_m2w  in  1 : memory-writeback instruction writes rd_m2w
//   load_m2w    in  1 : memory-writeback instruction is a load
//   mem_ready   in  1 : data memory response valid
//   match       out 1 : RAW match (x0 never matches)
//   fwd         out 1 : select writeback data for this operand
module pipe_fwd_unit (
  input  logic [4:0] rs,
  input  logic [4:0] rd_m2w,
  input  logic       reg_wr_m2w,
  input  logic       load_m2w,
  input  logic       mem_ready,
  output logic       match,
  output logic       fwd
);

  assign match = reg_wr_m2w && (rd_m2w != 5'd0) && (rd_m2w == rs);

`ifdef PIPE_CTRL_FWD_EN
  // A load whose data has not arrived yet has nothing to forward.
  assign fwd = match && !(load_m2w && !mem_ready);
`else
  logic unused_ld;
  assign unused_ld = load_m2w & mem_ready;
  assign fwd       = 1'b0;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward control and trap-redirect sequencing
// for the 3-stage fetch / decode-execute / memory-writeback pipeline.
// Build option: PIPE_CTRL_FWD_EN (forwarding instead of RAW stalls).
// Ports:
//   clk, rst (sync, active-high)
//   rs1_de, rs2_de, rd_m2w, reg_wr_m2w, load_m2w  : hazard inputs
//   mem_req_m2w, mem_ready                         : data memory handshake
//   br_taken, illegal_instr                        : control-flow events
//   stall_f, stall_de, flush_de, flush_m2w         : pipeline controls
//   fwd_a, fwd_b                                   : operand forward selects
//   trap_req, trap_cause                           : trap redirect
//   ctrl_state, stall_cnt                          : debug / statistics
//
// state    | meaning
// RUN      | normal issue; resolves mem wait, traps, branches, RAW
// MEM_WAIT | stalled on data memory; counts toward bus timeout
// FLUSH    | one bubble after a taken branch
// TRAP     | pipeline held flushed while fetch redirects to trap vector
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TRAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_de,
  input  logic [4:0]  rs2_de,
  input  logic [4:0]  rd_m2w,
  input  logic        reg_wr_m2w,
  input  logic        load_m2w,
  input  logic        mem_req_m2w,
  input  logic        mem_ready,
  input  logic        br_taken,
  input  logic        illegal_instr,
  output logic        stall_f,
  output logic        stall_de,
  output logic        flush_de,
  output logic        flush_m2w,
  output logic        fwd_a,
  output logic        fwd_b,
  output logic        trap_req,
  output logic [1:0]  trap_cause,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cnt
);

  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_MEMW  = MEM_WAIT;
  localparam logic [1:0] ST_FLUSH = FLUSH;
  localparam logic [1:0] ST_TRAP  = TRAP;
  localparam int CNT_W = cnt_width(MEM_TIMEOUT, TRAP_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;  // timeout count in MEM_WAIT, hold count in TRAP
  logic [1:0]       cause_q, cause_d;
  logic             stall_c, flush_de_c, flush_m2w_c, trap_c;
  logic             match_a, match_b, fwd_a_u, fwd_b_u;
  logic             raw_hit, raw_stall;

  pipe_fwd_unit u_fwd_a (
    .rs(rs1_de), .rd_m2w(rd_m2w), .reg_wr_m2w(reg_wr_m2w),
    .load_m2w(load_m2w), .mem_ready(mem_ready), .match(match_a), .fwd(fwd_a_u)
  );

  pipe_fwd_unit u_fwd_b (
    .rs(rs2_de), .rd_m2w(rd_m2w), .reg_wr_m2w(reg_wr_m2w),
    .load_m2w(load_m2w), .mem_ready(mem_ready), .match(match_b), .fwd(fwd_b_u)
  );

`ifdef PIPE_CTRL_FWD_EN
  logic unused_match;
  assign unused_match = match_a | match_b;
  assign raw_hit      = 1'b0;
`else
  // Masks the match for the cycle after a RAW stall, by which time the
  // producer has written the register file on the negedge.
  logic served_q;
  assign raw_hit = (match_a | match_b) & ~served_q;

  always_ff @(posedge clk) begin
    if (rst) served_q <= 1'b0;
    else     served_q <= raw_stall;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cause_d     = cause_q;
    stall_c     = 1'b0;
    flush_de_c  = 1'b0;
    flush_m2w_c = 1'b0;
    trap_c      = 1'b0;
    raw_stall   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_req_m2w && !mem_ready) begin
          stall_c = 1'b1;
          cnt_d   = CNT_W'(1);  // this cycle is the first waited cycle
          state_d = ST_MEMW;
        end else if (illegal_instr) begin
          trap_c      = 1'b1;
          cause_d     = ILLEGAL;
          flush_de_c  = 1'b1;
          flush_m2w_c = 1'b1;
          cnt_d       = '0;
          state_d     = ST_TRAP;
        end else if (br_taken) begin
          flush_de_c = 1'b1;
          state_d    = ST_FLUSH;
        end else if (raw_hit) begin
          stall_c     = 1'b1;
          flush_m2w_c = 1'b1;
          raw_stall   = 1'b1;
        end
      end
      ST_MEMW: begin
        stall_c = 1'b1;
        if (mem_ready) begin
          stall_c = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          trap_c      = 1'b1;
          cause_d     = BUS_TIMEOUT;
          flush_de_c  = 1'b1;
          flush_m2w_c = 1'b1;
          cnt_d       = '0;
          state_d     = ST_TRAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        flush_de_c = 1'b1;
        state_d    = ST_RUN;
      end
      default: begin
        flush_de_c  = 1'b1;
        flush_m2w_c = 1'b1;
        if (cnt_q == CNT_W'(TRAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      cause_q   <= NONE;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      if (stall_c && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Reset overrides every combinational control so no trap leaks out.
  assign stall_f    = stall_c & ~rst;
  assign stall_de   = stall_c & ~rst;
  assign flush_de   = flush_de_c & ~rst;
  assign flush_m2w  = flush_m2w_c & ~rst;
  assign fwd_a      = fwd_a_u & ~rst;
  assign fwd_b      = fwd_b_u & ~rst;
  assign trap_req   = trap_c & ~rst;
  assign trap_cause = rst ? 2'd0 : cause_d;
  assign ctrl_state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_de, rs2_de, rd_m2w;
  logic        reg_wr_m2w, load_m2w, mem_req_m2w, mem_ready, br_taken, illegal_instr;
  logic        stall_f, stall_de, flush_de, flush_m2w, fwd_a, fwd_b, trap_req;
  logic [1:0]  trap_cause, ctrl_state;
  logic [31:0] stall_cnt;
  logic [8:0]  ctl;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_scnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .TRAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .rs1_de(rs1_de), .rs2_de(rs2_de), .rd_m2w(rd_m2w),
    .reg_wr_m2w(reg_wr_m2w), .load_m2w(load_m2w), .mem_req_m2w(mem_req_m2w),
    .mem_ready(mem_ready), .br_taken(br_taken), .illegal_instr(illegal_instr),
    .stall_f(stall_f), .stall_de(stall_de), .flush_de(flush_de), .flush_m2w(flush_m2w),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .trap_req(trap_req), .trap_cause(trap_cause),
    .ctrl_state(ctrl_state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // {stall_f, stall_de, flush_de, flush_m2w, fwd_a, fwd_b, trap_req, trap_cause}
  assign ctl = {stall_f, stall_de, flush_de, flush_m2w, fwd_a, fwd_b, trap_req, trap_cause};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rs1_de = 0; rs2_de = 0; rd_m2w = 0; reg_wr_m2w = 0; load_m2w = 0;
    mem_req_m2w = 0; mem_ready = 0; br_taken = 0; illegal_instr = 0;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    exp_scnt = 0;
    tick(); tick();
    #1;
    chk("reset_ctl", 32'(ctl), 32'h0);
    chk("reset_state", 32'(ctrl_state), 32'd0);
    chk("reset_scnt", stall_cnt, 32'd0);
    rst = 1'b0;
    tick();

    // RAW on rs1 = x5
    rd_m2w = 5; reg_wr_m2w = 1; rs1_de = 5;
    #1;
`ifdef PIPE_CTRL_FWD_EN
    chk("raw_a_c1", 32'(ctl), 32'b000010000);
    tick(); #1;
    chk("raw_a_c2", 32'(ctl), 32'b000010000);
`else
    chk("raw_a_c1", 32'(ctl), 32'b110100000);
    exp_scnt = exp_scnt + 1;
    tick(); #1;
    chk("raw_a_c2", 32'(ctl), 32'b000000000);
`endif
    clear_in();
    tick();
    chk("raw_a_scnt", stall_cnt, exp_scnt);

    // x0 destination never matches
    rd_m2w = 0; reg_wr_m2w = 1; rs1_de = 0; rs2_de = 0;
    #1;
    chk("x0_ctl", 32'(ctl), 32'h0);
    clear_in();
    tick();

    // RAW on rs2 = x7 behind a load, data arriving one cycle later
    rd_m2w = 7; reg_wr_m2w = 1; rs2_de = 7; load_m2w = 1; mem_ready = 0;
    #1;
`ifdef PIPE_CTRL_FWD_EN
    chk("raw_b_load_wait", 32'(ctl), 32'b000000000);
    tick();
    mem_ready = 1; #1;
    chk("raw_b_load_rdy", 32'(ctl), 32'b000001000);
`else
    chk("raw_b_load_wait", 32'(ctl), 32'b110100000);
    exp_scnt = exp_scnt + 1;
    tick();
    mem_ready = 1; #1;
    chk("raw_b_load_rdy", 32'(ctl), 32'b000000000);
`endif
    clear_in();
    tick();
    chk("raw_b_scnt", stall_cnt, exp_scnt);

    // memory wait: ready low 3 cycles then high
    mem_req_m2w = 1; mem_ready = 0;
    #1;
    chk("memw_c1", 32'(ctl), 32'b110000000);
    tick();
    chk("memw_c2_state", 32'(ctrl_state), 32'd1);
    chk("memw_c2", 32'(ctl), 32'b110000000);
    tick();
    chk("memw_c3", 32'(ctl), 32'b110000000);
    tick();
    mem_ready = 1; #1;
    chk("memw_rdy", 32'(ctl), 32'b000000000);
    exp_scnt = exp_scnt + 3;
    tick();
    clear_in(); #1;
    chk("memw_done_state", 32'(ctrl_state), 32'd0);
    chk("memw_scnt", stall_cnt, exp_scnt);

    // bus timeout: trap in cycle 16
    mem_req_m2w = 1; mem_ready = 0;
    for (int i = 1; i <= 15; i++) begin
      #1;
      chk($sformatf("tmo_notrap_%0d", i), 32'(trap_req), 32'd0);
      tick();
    end
    #1;
    chk("tmo_trap", 32'(ctl), 32'b111100110);
    tick();
    clear_in(); #1;
    chk("tmo_trap1_state", 32'(ctrl_state), 32'd3);
    chk("tmo_trap1", 32'(ctl), 32'b001100010);
    tick();
    chk("tmo_trap2", 32'(ctl), 32'b001100010);
    tick();
    chk("tmo_run_state", 32'(ctrl_state), 32'd0);
    chk("tmo_run_ctl", 32'(ctl), 32'b000000010);

    // branch: flush event cycle plus FLUSH, branch in FLUSH ignored
    br_taken = 1; #1;
    chk("br_c1", 32'(ctl), 32'b001000010);
    tick();
    chk("br_flush_state", 32'(ctrl_state), 32'd2);
    chk("br_c2", 32'(ctl), 32'b001000010);
    tick();
    br_taken = 0; #1;
    chk("br_after_state", 32'(ctrl_state), 32'd0);
    chk("br_after_ctl", 32'(ctl), 32'b000000010);

    // illegal + branch together: trap wins, then reset mid-TRAP
    illegal_instr = 1; br_taken = 1; #1;
    chk("ill_ctl", 32'(ctl), 32'b001100101);
    tick();
    chk("ill_trap1_state", 32'(ctrl_state), 32'd3);
    chk("ill_trap1", 32'(ctl), 32'b001100001);
    tick();
    rst = 1; #1;
    chk("ill_rst_ctl", 32'(ctl), 32'h0);
    tick();
    rst = 0;
    clear_in(); #1;
    chk("ill_rst_state", 32'(ctrl_state), 32'd0);
    chk("ill_rst_after", 32'(ctl), 32'h0);
    chk("ill_rst_scnt", stall_cnt, 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
